// File: rtl/pll_rst_pkg.sv
// rtl/pll_rst_pkg.sv - shared state encoding for the PLL reset sequencer
package pll_rst_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - lock-qualified reset release for the PLL clock domain
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int HEARTBEAT_DIV      = 24,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pll_lock,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic [STATE_W-1:0]    state,
    output logic [LOSS_CNT_W-1:0] lock_loss_count,
    output logic                  led
);

    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                             LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

    logic                     lock_s;
    pll_state_e               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [LOSS_CNT_W-1:0]    loss_q, loss_d;
    logic [HEARTBEAT_DIV-1:0] hb_q, hb_d;
    logic                     sys_rst_n_q, sys_rst_n_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (resetn),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // A lock drop is tested before count completion so it always wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        loss_d  = loss_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    if (loss_q != {LOSS_CNT_W{1'b1}}) begin
                        loss_d = loss_q + LOSS_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase

        // Keyed on next state so the reset output and led move on the same edge as state.
        sys_rst_n_d = (state_d == RUN);
        hb_d        = (state_d == RUN) ? hb_q + HEARTBEAT_DIV'(1) : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            loss_q      <= '0;
            hb_q        <= '0;
            sys_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            hb_q        <= hb_d;
            sys_rst_n_q <= sys_rst_n_d;
        end
    end

    assign sys_rst_n       = sys_rst_n_q;
    assign ready           = sys_rst_n_q;
    assign state           = state_q;
    assign lock_loss_count = loss_q;
    assign led             = hb_q[HEARTBEAT_DIV-1];

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - randomized scoreboard bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    localparam int L   = 8;
    localparam int R   = 4;
    localparam int HB  = 3;
    localparam int LW  = 2;
    localparam int SAT = (1 << LW) - 1;

    typedef struct packed {
        logic [1:0]    st;
        logic          rst;
        logic          rdy;
        logic [LW-1:0] loss;
        logic          led;
    } obs_t;

    logic          clk;
    logic          resetn;
    logic          pll_lock;
    logic          sys_rst_n;
    logic          ready;
    logic [1:0]    state;
    logic [LW-1:0] lock_loss_count;
    logic          led;

    int checks = 0;
    int errors = 0;

    obs_t exp_q[$];

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES (L),
        .RESET_HOLD_CYCLES  (R),
        .HEARTBEAT_DIV      (HB),
        .LOSS_CNT_W         (LW)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .pll_lock        (pll_lock),
        .sys_rst_n       (sys_rst_n),
        .ready           (ready),
        .state           (state),
        .lock_loss_count (lock_loss_count),
        .led             (led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t observe();
        obs_t o;
        o.st   = state;
        o.rst  = sys_rst_n;
        o.rdy  = ready;
        o.loss = lock_loss_count;
        o.led  = led;
        return o;
    endfunction

    // Reference model: n = number of consecutive clock edges at which the
    // synchronized lock (the raw lock sampled two edges earlier) was high.
    // The state, reset and heartbeat follow from n by plain arithmetic.
    logic m_p0, m_p1, m_used;
    int   m_n;
    int   m_loss;
    obs_t m_e;

    always @(posedge clk) begin
        if (!resetn) begin
            m_p0   = 1'b0;
            m_p1   = 1'b0;
            m_n    = 0;
            m_loss = 0;
        end else begin
            m_used = m_p1;
            m_p1   = m_p0;
            m_p0   = pll_lock;
            if (m_used) begin
                m_n = m_n + 1;
            end else begin
                if (m_n > L + R && m_loss < SAT) m_loss = m_loss + 1;
                m_n = 0;
            end
        end
        m_e.st   = (m_n == 0) ? 2'd0 : (m_n <= L) ? 2'd1 : (m_n <= L + R) ? 2'd2 : 2'd3;
        m_e.rst  = (m_n > L + R);
        m_e.rdy  = (m_n > L + R);
        m_e.loss = LW'(m_loss);
        m_e.led  = (m_n > L + R) ? 1'(((m_n - L - R) >> (HB - 1)) & 1) : 1'b0;
        exp_q.push_back(m_e);
    end

    always @(posedge clk) begin
        obs_t act, exp_v;
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            exp_v = exp_q.pop_front();
            act   = observe();
            if (act !== exp_v) begin
                errors++;
                $display("FAIL cycle_outputs at %0t: got st=%0d rst=%0b rdy=%0b loss=%0d led=%0b, want st=%0d rst=%0b rdy=%0b loss=%0d led=%0b",
                         $time, act.st, act.rst, act.rdy, act.loss, act.led,
                         exp_v.st, exp_v.rst, exp_v.rdy, exp_v.loss, exp_v.led);
            end
        end
    end

    task automatic check_reset_values(input string name);
        obs_t act;
        act = observe();
        checks++;
        if (act !== obs_t'(0)) begin
            errors++;
            $display("FAIL %s at %0t: got st=%0d rst=%0b rdy=%0b loss=%0d led=%0b, want all zero",
                     name, $time, act.st, act.rst, act.rdy, act.loss, act.led);
        end
    endtask

    task automatic drive(input logic v, input int cycles);
        pll_lock = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic async_reset(input string name);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check_reset_values(name);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn   = 1'b0;
        pll_lock = 1'b0;
        #1;
        check_reset_values("reset_state");
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        drive(1'b0, 3);
        drive(1'b1, 30);

        drive(1'b0, 3);
        drive(1'b1, 5);
        drive(1'b0, 2);
        drive(1'b1, 24);

        for (int i = 0; i < 6; i++) begin
            drive(1'b0, $urandom_range(1, 5));
            drive(1'b1, $urandom_range(14, 30));
        end

        for (int i = 0; i < 12; i++) begin
            drive(1'b0, $urandom_range(1, 4));
            drive(1'b1, $urandom_range(1, 25));
        end

        drive(1'b0, 4);
        pll_lock = 1'b1;
        repeat (11) @(negedge clk);
        async_reset("async_reset_mid_hold");
        drive(1'b1, 20);
        async_reset("async_reset_mid_run");
        drive(1'b1, 20);
        drive(1'b0, 5);
        drive(1'b1, 18);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
